// File: rtl/rsbus_d2r_mgr_ffbnk_p.sv
`default_nettype none
// ============================================================================
// Module   : rsbus_d2r_mgr_ffbnk_p
// Brief    : Per-priority request FIFO bank with starvation-bounded arbitration
//            onto a single registered output stage and sticky error reporting.
// Revision : 1.0 - initial parametrised release
// ============================================================================
module rsbus_d2r_mgr_ffbnk_p #(
    parameter int PRIOR_NUM    = 4,
    parameter int PRIOR_W      = 2,
    parameter int DAT_W        = 8,
    parameter int DEPTH        = 16,
    parameter int AF_LIMIT     = DEPTH - 3,
    parameter int AE_LIMIT     = 3,
    parameter int STARVE_LIMIT = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_stb,
    input  logic [PRIOR_W-1:0]   i_prior,
    input  logic [DAT_W-1:0]     i_dat,
    output logic [PRIOR_NUM-1:0] i_af,
    output logic                 o_stb,
    output logic [PRIOR_W-1:0]   o_prior,
    output logic [DAT_W-1:0]     o_dat,
    input  logic                 o_ack,
    output logic                 o_ff_err,
    output logic                 o_starve
);
    localparam int c_ptr_w  = $clog2(DEPTH);
    localparam int c_cnt_w  = c_ptr_w + 1;
    localparam int c_age_w  = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam int c_plim_w = PRIOR_W + 1;
    localparam logic [c_cnt_w-1:0]  c_depth     = c_cnt_w'(DEPTH);
    localparam logic [c_cnt_w-1:0]  c_af_lim    = c_cnt_w'(AF_LIMIT);
    localparam logic [c_cnt_w-1:0]  c_ae_lim    = c_cnt_w'(AE_LIMIT);
    localparam logic [c_age_w-1:0]  c_starve    = c_age_w'(STARVE_LIMIT);
    localparam logic [c_plim_w-1:0] c_prior_lim = c_plim_w'(PRIOR_NUM);

    logic [c_cnt_w-1:0]   w_cnt  [PRIOR_NUM];
    logic [c_age_w-1:0]   w_age  [PRIOR_NUM];
    logic [DAT_W-1:0]     w_head [PRIOR_NUM];
    logic [PRIOR_NUM-1:0] w_nempty;
    logic [PRIOR_NUM-1:0] w_push;
    logic [PRIOR_NUM-1:0] w_pop;
    logic                 w_prior_ok;
    logic                 w_tgt_full;
    logic                 w_wr_err;
    logic                 w_ack_err;
    logic                 w_load;
    logic                 w_forced;
    logic [PRIOR_W-1:0]   w_sel;
    logic [DAT_W-1:0]     w_sel_dat;

    logic                 r_stb;
    logic [PRIOR_W-1:0]   r_prior;
    logic [DAT_W-1:0]     r_dat;
    logic                 r_ff_err;
    logic                 r_starve;

    assign w_prior_ok = ({1'b0, i_prior} < c_prior_lim);

    always_comb begin
        w_tgt_full = 1'b0;
        for (int c = 0; c < PRIOR_NUM; c++) begin
            if ((i_prior == PRIOR_W'(c)) && (w_cnt[c] == c_depth)) begin
                w_tgt_full = 1'b1;
            end
        end
    end

    assign w_wr_err  = i_stb && (!w_prior_ok || w_tgt_full);
    assign w_ack_err = o_ack && !r_stb;
    assign w_load    = (!r_stb || o_ack) && (|w_nempty);

    // Ascending scans leave the highest qualifying index selected; a starved
    // channel overrides plain priority.
    always_comb begin
        w_sel     = '0;
        w_sel_dat = '0;
        w_forced  = 1'b0;
        for (int c = 0; c < PRIOR_NUM; c++) begin
            if (w_nempty[c]) begin
                w_sel     = PRIOR_W'(c);
                w_sel_dat = w_head[c];
            end
        end
        if (STARVE_LIMIT != 0) begin
            for (int c = 0; c < PRIOR_NUM; c++) begin
                if (w_nempty[c] && (w_age[c] == c_starve)) begin
                    w_sel     = PRIOR_W'(c);
                    w_sel_dat = w_head[c];
                    w_forced  = 1'b1;
                end
            end
        end
    end

    for (genvar c = 0; c < PRIOR_NUM; c++) begin : g_ch
        logic [DAT_W-1:0]   r_mem [DEPTH];
        logic [c_ptr_w-1:0] r_wptr;
        logic [c_ptr_w-1:0] r_rptr;
        logic [c_cnt_w-1:0] r_cnt;
        logic [c_age_w-1:0] r_age;
        logic               r_af;

        assign w_push[c]   = i_stb && w_prior_ok && (i_prior == PRIOR_W'(c)) && (r_cnt != c_depth);
        assign w_pop[c]    = w_load && (w_sel == PRIOR_W'(c));
        assign w_nempty[c] = (r_cnt != '0);
        assign w_cnt[c]    = r_cnt;
        assign w_age[c]    = r_age;
        assign w_head[c]   = r_mem[r_rptr];
        assign i_af[c]     = r_af;

        always_ff @(posedge clk) begin
            if (w_push[c]) begin
                r_mem[r_wptr] <= i_dat;
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                r_wptr <= '0;
                r_rptr <= '0;
                r_cnt  <= '0;
                r_age  <= '0;
                r_af   <= 1'b0;
            end else begin
                if (w_push[c]) begin
                    r_wptr <= r_wptr + c_ptr_w'(1);
                end
                if (w_pop[c]) begin
                    r_rptr <= r_rptr + c_ptr_w'(1);
                end
                if (w_push[c] && !w_pop[c]) begin
                    r_cnt <= r_cnt + c_cnt_w'(1);
                end else if (!w_push[c] && w_pop[c]) begin
                    r_cnt <= r_cnt - c_cnt_w'(1);
                end
                // Hysteresis band: between the limits the flag keeps its value.
                if (r_cnt >= c_af_lim) begin
                    r_af <= 1'b1;
                end else if (r_cnt <= c_ae_lim) begin
                    r_af <= 1'b0;
                end
                if (w_load) begin
                    if (w_pop[c] || !w_nempty[c]) begin
                        r_age <= '0;
                    end else if (r_age != c_starve) begin
                        r_age <= r_age + c_age_w'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stb    <= 1'b0;
            r_prior  <= '0;
            r_dat    <= '0;
            r_ff_err <= 1'b0;
            r_starve <= 1'b0;
        end else begin
            r_starve <= w_load && w_forced;
            if (w_load) begin
                r_stb   <= 1'b1;
                r_prior <= w_sel;
                r_dat   <= w_sel_dat;
            end else if (o_ack) begin
                r_stb <= 1'b0;
            end
            if (w_wr_err || w_ack_err) begin
                r_ff_err <= 1'b1;
            end
        end
    end

    assign o_stb    = r_stb;
    assign o_prior  = r_prior;
    assign o_dat    = r_dat;
    assign o_ff_err = r_ff_err;
    assign o_starve = r_starve;

endmodule
`default_nettype wire

// File: tb/tb_rsbus_d2r_mgr_ffbnk_p.sv
`default_nettype none
// Bench for rsbus_d2r_mgr_ffbnk_p: directed scenarios plus random traffic,
// every cycle compared against a queue-based reference model.
module tb_rsbus_d2r_mgr_ffbnk_p;
    localparam int N   = 4;
    localparam int PW  = 3;
    localparam int DW  = 8;
    localparam int D   = 16;
    localparam int AFL = 13;
    localparam int AEL = 3;
    localparam int SL  = 3;

    logic          clk     = 1'b0;
    logic          rst     = 1'b1;
    logic          i_stb   = 1'b0;
    logic [PW-1:0] i_prior = '0;
    logic [DW-1:0] i_dat   = '0;
    logic          o_ack   = 1'b0;
    logic [N-1:0]  i_af;
    logic          o_stb;
    logic [PW-1:0] o_prior;
    logic [DW-1:0] o_dat;
    logic          o_ff_err;
    logic          o_starve;

    always #5 clk = ~clk;

    rsbus_d2r_mgr_ffbnk_p #(
        .PRIOR_NUM    (N),
        .PRIOR_W      (PW),
        .DAT_W        (DW),
        .DEPTH        (D),
        .AF_LIMIT     (AFL),
        .AE_LIMIT     (AEL),
        .STARVE_LIMIT (SL)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .i_stb    (i_stb),
        .i_prior  (i_prior),
        .i_dat    (i_dat),
        .i_af     (i_af),
        .o_stb    (o_stb),
        .o_prior  (o_prior),
        .o_dat    (o_dat),
        .o_ack    (o_ack),
        .o_ff_err (o_ff_err),
        .o_starve (o_starve)
    );

    int n_total = 0;
    int n_bad   = 0;

    logic [DW-1:0] mq [N][$];
    int            m_age [N];
    logic [N-1:0]  m_af     = '0;
    logic          m_stb    = 1'b0;
    logic          m_err    = 1'b0;
    logic          m_starve = 1'b0;
    int            m_prior  = 0;
    logic [DW-1:0] m_dat    = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step(input bit r, input bit s, input int p, input logic [DW-1:0] d, input bit a);
        int            sz [N];
        int            sel;
        bit            forced;
        bit            any;
        bit            load;
        logic [DW-1:0] popped;
        if (r) begin
            for (int c = 0; c < N; c++) begin
                mq[c].delete();
                m_age[c] = 0;
            end
            m_af = '0; m_stb = 1'b0; m_prior = 0; m_dat = '0; m_err = 1'b0; m_starve = 1'b0;
            return;
        end
        any = 1'b0;
        for (int c = 0; c < N; c++) begin
            sz[c] = mq[c].size();
            if (sz[c] > 0) any = 1'b1;
        end
        load   = (!m_stb || a) && any;
        sel    = -1;
        forced = 1'b0;
        for (int c = N - 1; c >= 0; c--) begin
            if (sel < 0 && sz[c] > 0 && m_age[c] == SL) begin
                sel = c;
                forced = 1'b1;
            end
        end
        if (sel < 0) begin
            for (int c = N - 1; c >= 0; c--) begin
                if (sel < 0 && sz[c] > 0) sel = c;
            end
        end
        if (a && !m_stb) m_err = 1'b1;
        for (int c = 0; c < N; c++) begin
            if (sz[c] >= AFL) m_af[c] = 1'b1;
            else if (sz[c] <= AEL) m_af[c] = 1'b0;
        end
        m_starve = load && forced;
        if (load) begin
            popped = mq[sel].pop_front();
            for (int c = 0; c < N; c++) begin
                if (c == sel) m_age[c] = 0;
                else if (sz[c] > 0) m_age[c] = (m_age[c] < SL) ? m_age[c] + 1 : SL;
                else m_age[c] = 0;
            end
            m_stb = 1'b1; m_prior = sel; m_dat = popped;
        end else if (a) begin
            m_stb = 1'b0;
        end
        if (s) begin
            if (p >= N) m_err = 1'b1;
            else if (sz[p] >= D) m_err = 1'b1;
            else mq[p].push_back(d);
        end
    endtask

    // One clock: drive on negedge, step the model at the edge, compare 1ns later.
    task automatic cyc(input bit r, input bit s, input int p, input logic [DW-1:0] d, input bit a);
        @(negedge clk);
        rst = r; i_stb = s; i_prior = PW'(p); i_dat = d; o_ack = a;
        @(posedge clk);
        model_step(r, s, p, d, a);
        #1;
        chk("stb", 32'(o_stb), 32'(m_stb));
        if (m_stb) begin
            chk("dat", 32'(o_dat), 32'(m_dat));
            chk("prior", 32'(o_prior), m_prior);
        end
        chk("af", 32'(i_af), 32'(m_af));
        chk("ff_err", 32'(o_ff_err), 32'(m_err));
        chk("starve", 32'(o_starve), 32'(m_starve));
    endtask

    task automatic rst_bank();
        cyc(1, 0, 0, 8'h00, 0);
        cyc(1, 0, 0, 8'h00, 0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_stb"}, 32'(o_stb), 0);
        chk({tag, "_prior"}, 32'(o_prior), 0);
        chk({tag, "_dat"}, 32'(o_dat), 0);
        chk({tag, "_af"}, 32'(i_af), 0);
        chk({tag, "_err"}, 32'(o_ff_err), 0);
        chk({tag, "_starve"}, 32'(o_starve), 0);
    endtask

    initial begin
        rst_bank();
        chk_zero("reset");

        // single word with o_ack held high
        cyc(0, 1, 0, 8'hA5, 1);
        chk("single_t1_stb", 32'(o_stb), 0);
        cyc(0, 0, 0, 8'h00, 1);
        chk("single_t2_stb", 32'(o_stb), 1);
        chk("single_dat", 32'(o_dat), 32'hA5);
        chk("single_prior", 32'(o_prior), 0);
        cyc(0, 0, 0, 8'h00, 1);
        chk("single_t3_stb", 32'(o_stb), 0);

        // priority: filler occupies the output stage while ch0 and ch3 queue
        rst_bank();
        cyc(0, 1, 1, 8'h77, 0);
        cyc(0, 1, 0, 8'h10, 0);
        cyc(0, 1, 3, 8'h33, 0);
        cyc(0, 0, 0, 8'h00, 1);
        chk("prio_first", 32'(o_dat), 32'h33);
        cyc(0, 0, 0, 8'h00, 1);
        chk("prio_second", 32'(o_dat), 32'h10);
        cyc(0, 0, 0, 8'h00, 1);
        chk("prio_empty", 32'(o_stb), 0);

        // starvation: ch3 kept busy, ch1 waits SL lost arbitrations
        rst_bank();
        cyc(0, 1, 3, 8'hA0, 0);
        cyc(0, 1, 3, 8'hA1, 0);
        cyc(0, 1, 3, 8'hA2, 0);
        cyc(0, 1, 1, 8'hB1, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 1, 3, 8'(32'hA3 + i), 1);
            chk("starve_hi_prior", 32'(o_prior), 3);
            chk("starve_hi_dat", 32'(o_dat), 32'hA1 + i);
        end
        cyc(0, 1, 3, 8'hA6, 1);
        chk("starve_lo_dat", 32'(o_dat), 32'hB1);
        chk("starve_lo_prior", 32'(o_prior), 1);
        chk("starve_pulse", 32'(o_starve), 1);
        cyc(0, 0, 0, 8'h00, 1);
        chk("starve_pulse_end", 32'(o_starve), 0);

        // overflow of ch2 while the output stage is held
        rst_bank();
        cyc(0, 1, 0, 8'hEE, 0);
        for (int i = 0; i < 17; i++) begin
            cyc(0, 1, 2, 8'(32'h40 + i), 0);
            if (i == 15) chk("ovf_err_before", 32'(o_ff_err), 0);
        end
        chk("ovf_err_after", 32'(o_ff_err), 1);
        for (int i = 0; i < 16; i++) begin
            cyc(0, 0, 0, 8'h00, 1);
            chk("ovf_drain", 32'(o_dat), 32'h40 + i);
        end
        cyc(0, 0, 0, 8'h00, 1);
        chk("ovf_drained", 32'(o_stb), 0);

        // almost-full hysteresis on ch1
        rst_bank();
        cyc(0, 1, 0, 8'h01, 0);
        for (int i = 0; i < 13; i++) cyc(0, 1, 1, 8'(i), 0);
        chk("hys_set_lag", 32'(i_af[1]), 0);
        cyc(0, 0, 0, 8'h00, 0);
        chk("hys_set", 32'(i_af[1]), 1);
        for (int i = 0; i < 9; i++) cyc(0, 0, 0, 8'h00, 1);
        cyc(0, 0, 0, 8'h00, 0);
        chk("hys_hold_at4", 32'(i_af[1]), 1);
        cyc(0, 0, 0, 8'h00, 1);
        chk("hys_hold_lag", 32'(i_af[1]), 1);
        cyc(0, 0, 0, 8'h00, 0);
        chk("hys_clear", 32'(i_af[1]), 0);

        // errors, mid-stream reset and recovery
        rst_bank();
        cyc(0, 0, 0, 8'h00, 1);
        chk("ack_idle_err", 32'(o_ff_err), 1);
        rst_bank();
        cyc(0, 1, 5, 8'h55, 0);
        chk("bad_prior_err", 32'(o_ff_err), 1);
        cyc(0, 0, 0, 8'h00, 0);
        chk("bad_prior_nowrite", 32'(o_stb), 0);
        for (int i = 0; i < 6; i++) cyc(0, 1, i % 4, 8'(32'h60 + i), 1);
        cyc(1, 0, 0, 8'h00, 1);
        chk_zero("mid_rst");
        cyc(0, 0, 0, 8'h00, 0);
        chk("mid_rst_empty", 32'(o_stb), 0);
        cyc(0, 1, 0, 8'hC3, 0);
        chk("post_rst_t1", 32'(o_stb), 0);
        cyc(0, 0, 0, 8'h00, 0);
        chk("post_rst_t2", 32'(o_stb), 1);
        chk("post_rst_dat", 32'(o_dat), 32'hC3);

        // random traffic
        rst_bank();
        for (int i = 0; i < 3000; i++) begin
            bit r;
            bit s;
            bit a;
            int p;
            r = ($urandom_range(0, 299) == 0);
            s = ($urandom_range(0, 99) < 60);
            p = ($urandom_range(0, 49) == 0) ? int'($urandom_range(4, 7)) : int'($urandom_range(0, 3));
            a = m_stb ? ($urandom_range(0, 99) < 55) : ($urandom_range(0, 99) == 0);
            cyc(r, s, p, 8'($urandom), a);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rsbus_d2r_mgr_ffbnk_p.md
# rsbus_d2r_mgr_ffbnk_p

Parametrised request FIFO bank for the rsbus device-to-ring manager. It buffers requests in one FIFO per priority class and arbitrates them onto a single registered output. Channel count, data width and depth are parameters, and it adds starvation-bounded arbitration with sticky error reporting. It sits between the device request port and the ring injector and replaces the fixed 4-priority, 8-bit bank.

## Interface
Parameters:
- PRIOR_NUM, 4, number of priority channels (2..8); highest index is the highest priority.
- PRIOR_W, 2, width of the priority field; must be at least clog2(PRIOR_NUM).
- DAT_W, 8, request word width.
- DEPTH, 16, entries per channel FIFO; a power of 2, at least 4.
- AF_LIMIT, DEPTH-3, fill level (count) at which i_af[c] sets.
- AE_LIMIT, 3, fill level (count) at or below which i_af[c] clears; must be less than AF_LIMIT.
- STARVE_LIMIT, 15, lost arbitrations before a channel is forced; 0 disables forcing.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- i_stb  in  1  write strobe.
- i_prior  in  PRIOR_W  target channel of the write; values at or above PRIOR_NUM are invalid.
- i_dat  in  DAT_W  request word.
- i_af  out  PRIOR_NUM  per-channel almost-full flag, with hysteresis.
- o_stb  out  1  output stage holds a request.
- o_prior  out  PRIOR_W  channel of the held request.
- o_dat  out  DAT_W  held request word.
- o_ack  in  1  consume; valid only while o_stb=1.
- o_ff_err  out  1  sticky error flag.
- o_starve  out  1  one-cycle pulse when a load was forced by starvation.

## Operation
- Reset state: all FIFO counts and pointers 0; all age counters 0. Every output is 0: i_af, o_stb, o_prior, o_dat, o_ff_err, o_starve.
- Write: i_stb=1 with i_prior=c pushes i_dat into FIFO c.
  - If count[c]==DEPTH before the edge, the word is dropped and o_ff_err sets. This applies even if FIFO c pops in the same cycle.
  - If i_prior>=PRIOR_NUM, nothing is written and o_ff_err sets.
- Output stage: a single register.
  - load = (o_stb==0 or o_ack==1) and any channel non-empty.
  - On load: o_dat, o_prior and o_stb=1 take the selected channel's head, and that FIFO pops.
  - If o_ack==1 and nothing is loadable, o_stb goes to 0.
  - o_ack while o_stb==0 is ignored and sets o_ff_err.
- Selection among non-empty channels:
  - If STARVE_LIMIT!=0 and some channel has age==STARVE_LIMIT, pick the highest-index starved channel and pulse o_starve.
  - Otherwise pick the highest-index non-empty channel.
- Age counters, updated only on load:
  - Selected channel: reset to 0.
  - Non-empty but not selected: saturating increment, capped at STARVE_LIMIT.
  - Empty channel: held at 0.
- Counts: push and pop on the same channel in the same cycle leave the count unchanged. Read and write pointers wrap modulo DEPTH.
- i_af[c]:
  - Sets when count[c]>=AF_LIMIT.
  - Once set, it holds until count[c]<=AE_LIMIT, then clears.
  - Evaluated on the registered count, so it follows the count by 1 cycle.
- o_ff_err clears only on rst.
- rst asserted mid-transfer discards all buffered data and the held word. The o_ack sampled during the rst cycle is ignored.

## Timing
- Write at edge T into an empty bank with the output stage empty gives o_stb=1 from cycle T+2. One cycle is FIFO count update; one is the output register.
- Sustained throughput is 1 word per cycle: o_ack held high with data available reloads on every edge.
- o_ack is sampled on the same cycle as o_stb (valid/ready style); no delayed-ack pipeline.
- o_starve is high in the cycle after the forced load, aligned with the new o_dat.
- Reset has 1 cycle latency; all outputs read 0 in the cycle after rst is sampled high.

## Test plan
- Single word: write 0xA5 to channel 0, o_ack tied 1 -> o_stb high at T+2 with o_dat=0xA5, o_prior=0, then low.
- Priority: preload ch0 = 0x10 and ch3 = 0x33, then assert o_ack -> output order 0x33 then 0x10.
- Starvation, STARVE_LIMIT=3: ch1 holds 1 word, ch3 is refilled continuously, o_ack held 1 -> three ch3 words, then the ch1 word with o_starve=1.
- Overflow, DEPTH=16: 17 writes to ch2 with o_ack=0 -> 16 words retained, o_ff_err=1 after the 17th. Drain yields the first 16 in order.
- Hysteresis, DEPTH=16: fill ch1 to 13 -> i_af[1]=1. Drain to 4 -> still 1. Drain to 3 -> 0 one cycle later.
- Errors and reset: o_ack with o_stb=0 -> o_ff_err=1. Then rst mid-stream -> all outputs 0 and all FIFOs empty. A later write to ch0 appears at T+2.
